// File: rtl/if_stage_pc_unit.sv
// Instruction-fetch front end: program counter, next-PC selection and the IF/ID
// pipeline register with stall/flush control and a fetched-instruction counter.
module if_stage_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        JumpTaken,
  input  logic [31:0] JumpTarget,
  input  logic [31:0] InstrIn,
  output logic [31:0] PCAddress,
  output logic [31:0] IFID_Instruction,
  output logic [31:0] IFID_PCPlus4,
  output logic        IFID_Valid,
  output logic [31:0] FetchCount
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        redirect;
  logic        bubble;

  assign pc_plus4  = pc + 32'd4;
  assign redirect  = JumpTaken | BranchTaken;
  assign bubble    = Flush | redirect;
  assign PCAddress = pc;

  // Redirects beat Stall so a resolved branch/jump is never lost to a hazard hold.
  always_comb begin
    next_pc = pc_plus4;
    if (JumpTaken) begin
      next_pc = {JumpTarget[31:2], 2'b00};
    end else if (BranchTaken) begin
      next_pc = {BranchTarget[31:2], 2'b00};
    end else if (Stall) begin
      next_pc = pc;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pc <= RESET_PC;
    end else begin
      pc <= next_pc;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      IFID_Instruction <= NOP_WORD;
      IFID_PCPlus4     <= 32'd0;
      IFID_Valid       <= 1'b0;
      FetchCount       <= 32'd0;
    end else if (bubble) begin
      IFID_Instruction <= NOP_WORD;
      IFID_PCPlus4     <= 32'd0;
      IFID_Valid       <= 1'b0;
    end else if (!Stall) begin
      IFID_Instruction <= InstrIn;
      IFID_PCPlus4     <= pc_plus4;
      IFID_Valid       <= 1'b1;
      FetchCount       <= FetchCount + 32'd1;
    end
  end

endmodule

// File: tb/tb_if_stage_pc_unit.sv
// Directed self-checking bench for if_stage_pc_unit; a second instance with
// RESET_PC = 32'hFFFF_FFFC exercises PC+4 wrap-around.
module tb_if_stage_pc_unit;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic        jumpTaken;
  logic [31:0] jumpTarget;

  logic [31:0] instrIn, pcAddress, ifidInstr, ifidPcPlus4, fetchCount;
  logic        ifidValid;
  logic [31:0] wInstrIn, wPcAddress, wIfidInstr, wIfidPcPlus4, wFetchCount;
  logic        wIfidValid;

  int checkCount = 0;
  int passCount  = 0;

  // Memory model: each word holds its word index times three.
  assign instrIn  = (pcAddress >> 2) * 32'd3;
  assign wInstrIn = (wPcAddress >> 2) * 32'd3;

  if_stage_pc_unit #(.RESET_PC(32'h0000_0000), .NOP_WORD(32'h0000_0000)) dut (
    .Clk(clock), .Reset(reset), .Stall(stall), .Flush(flush),
    .BranchTaken(branchTaken), .BranchTarget(branchTarget),
    .JumpTaken(jumpTaken), .JumpTarget(jumpTarget), .InstrIn(instrIn),
    .PCAddress(pcAddress), .IFID_Instruction(ifidInstr),
    .IFID_PCPlus4(ifidPcPlus4), .IFID_Valid(ifidValid), .FetchCount(fetchCount)
  );

  if_stage_pc_unit #(.RESET_PC(32'hFFFF_FFFC), .NOP_WORD(32'h0000_0000)) dutWrap (
    .Clk(clock), .Reset(reset), .Stall(stall), .Flush(flush),
    .BranchTaken(branchTaken), .BranchTarget(branchTarget),
    .JumpTaken(jumpTaken), .JumpTarget(jumpTarget), .InstrIn(wInstrIn),
    .PCAddress(wPcAddress), .IFID_Instruction(wIfidInstr),
    .IFID_PCPlus4(wIfidPcPlus4), .IFID_Valid(wIfidValid), .FetchCount(wFetchCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Compare one observed value with its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive one set of control inputs, take one rising edge, sample 1ns later.
  task automatic applyStimulus(input logic st, input logic fl,
                               input logic bt, input logic [31:0] btgt,
                               input logic jt, input logic [31:0] jtgt);
    stall = st; flush = fl;
    branchTaken = bt; branchTarget = btgt;
    jumpTaken = jt; jumpTarget = jtgt;
    @(posedge clock);
    #1;
  endtask

  task automatic checkIfid(input string tag, input logic [31:0] pc,
                           input logic [31:0] ins, input logic [31:0] p4,
                           input logic v, input logic [31:0] cnt);
    checkOutput({tag, " pc"},    pcAddress,   pc);
    checkOutput({tag, " instr"}, ifidInstr,   ins);
    checkOutput({tag, " pc4"},   ifidPcPlus4, p4);
    checkOutput({tag, " valid"}, {31'd0, ifidValid}, {31'd0, v});
    checkOutput({tag, " count"}, fetchCount,  cnt);
  endtask

  task automatic resetPulse();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    branchTaken = 1'b0; branchTarget = '0; jumpTaken = 1'b0; jumpTarget = '0;
    repeat (2) @(negedge clock);
    checkIfid("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    checkOutput("wrap reset pc", wPcAddress, 32'hFFFF_FFFC);
    reset = 1'b0;

    // Sequential fetch
    applyStimulus(0, 0, 0, 0, 0, 0); checkIfid("seq1", 32'd4,  32'd0, 32'd4,  1, 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0); checkIfid("seq2", 32'd8,  32'd3, 32'd8,  1, 32'd2);
    applyStimulus(0, 0, 0, 0, 0, 0); checkIfid("seq3", 32'd12, 32'd6, 32'd12, 1, 32'd3);
    applyStimulus(0, 0, 0, 0, 0, 0); checkIfid("seq4", 32'd16, 32'd9, 32'd16, 1, 32'd4);

    // Stall at PC=8
    resetPulse();
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0); checkIfid("prestall", 32'd8, 32'd3, 32'd8, 1, 32'd2);
    applyStimulus(1, 0, 0, 0, 0, 0); checkIfid("stall1",   32'd8, 32'd3, 32'd8, 1, 32'd2);
    applyStimulus(1, 0, 0, 0, 0, 0); checkIfid("stall2",   32'd8, 32'd3, 32'd8, 1, 32'd2);
    applyStimulus(0, 0, 0, 0, 0, 0); checkIfid("release",  32'd12, 32'd6, 32'd12, 1, 32'd3);

    // Branch at PC=12, then fetch from target
    applyStimulus(0, 0, 1, 32'h40, 0, 0); checkIfid("branch", 32'h40, 32'd0, 32'd0, 0, 32'd3);
    applyStimulus(0, 0, 0, 0, 0, 0);      checkIfid("btgt",   32'h44, 32'd48, 32'h44, 1, 32'd4);

    // Jump and branch together: jump wins, low bits cleared
    applyStimulus(0, 0, 1, 32'h20, 1, 32'h103); checkIfid("jmpbr", 32'h100, 32'd0, 32'd0, 0, 32'd4);

    // Reach PC=0x20 with a valid instruction in IF/ID, then stall+flush
    applyStimulus(0, 0, 0, 0, 1, 32'h1C); checkIfid("jmp1c", 32'h1C, 32'd0, 32'd0, 0, 32'd4);
    applyStimulus(0, 0, 0, 0, 0, 0);      checkIfid("at20",  32'h20, 32'd21, 32'h20, 1, 32'd5);
    applyStimulus(1, 1, 0, 0, 0, 0);      checkIfid("stflush", 32'h20, 32'd0, 32'd0, 0, 32'd5);
    applyStimulus(1, 0, 1, 32'h8, 0, 0);  checkIfid("stbranch", 32'h8, 32'd0, 32'd0, 0, 32'd5);
    applyStimulus(0, 0, 0, 0, 0, 0);      checkIfid("after8", 32'd12, 32'd6, 32'd12, 1, 32'd6);
    applyStimulus(0, 1, 0, 0, 0, 0);      checkIfid("flush",  32'd16, 32'd0, 32'd0, 0, 32'd6);

    // Asynchronous reset between edges while stalled
    applyStimulus(1, 0, 0, 0, 0, 0);
    #2 reset = 1'b1;
    #1 checkIfid("asyncrst", 32'h0, 32'h0, 32'h0, 0, 32'd0);
    checkOutput("wrap asyncrst pc", wPcAddress, 32'hFFFF_FFFC);
    stall = 1'b0;
    @(negedge clock);
    reset = 1'b0;

    // Redirect pulse that never reaches an edge has no effect
    #1 branchTaken = 1'b1; branchTarget = 32'h80;
    #1 branchTaken = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0); checkIfid("glitch", 32'd4, 32'd0, 32'd4, 1, 32'd1);
    checkOutput("wrap pc",    wPcAddress,   32'h0);
    checkOutput("wrap pc4",   wIfidPcPlus4, 32'h0);
    checkOutput("wrap instr", wIfidInstr,   32'hBFFF_FFFD);
    checkOutput("wrap valid", {31'd0, wIfidValid}, 32'd1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/if_stage_pc_unit.md
Name: if_stage_pc_unit

Overview:
Instruction-fetch front end of the single-issue MIPS pipeline. Holds the program counter, drives the fetch address to the instruction memory, and computes PC+4. Selects the next PC from sequential, branch or jump sources. Latches the returned instruction into the IF/ID pipeline register, with stall and flush (bubble) control from hazard logic.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_WORD, 32'h0000_0000, instruction word inserted into IF/ID on flush/reset (sll $0,$0,0)

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  asynchronous, active-high reset
Stall  input  1  hazard unit: hold PC and IF/ID contents
Flush  input  1  squash IF/ID (insert bubble)
BranchTaken  input  1  branch resolved taken this cycle
BranchTarget  input  32  branch destination byte address
JumpTaken  input  1  j/jal/jr resolved this cycle
JumpTarget  input  32  jump destination byte address
InstrIn  input  32  combinational read data from instruction memory at PCAddress
PCAddress  output  32  current PC; drives instruction memory Address
IFID_Instruction  output  32  registered instruction
IFID_PCPlus4  output  32  registered PC+4 of that instruction
IFID_Valid  output  1  1 = IF/ID holds a real instruction, 0 = bubble
FetchCount  output  32  number of instructions accepted into IF/ID since reset

Behaviour:
- All state is updated on the rising edge of Clk. Reset asserts asynchronously and overrides everything.
- Reset values: PC=RESET_PC, IFID_Instruction=NOP_WORD, IFID_PCPlus4=0, IFID_Valid=0, FetchCount=0.
- PCAddress is the PC register output directly, with no combinational path from any input.
- PCPlus4 = PC + 4, modulo 2^32: 32'hFFFF_FFFC wraps to 0.
- Next-PC priority, highest first:
  1. JumpTaken: PC <= {JumpTarget[31:2],2'b00}
  2. BranchTaken: PC <= {BranchTarget[31:2],2'b00}
  3. Stall: PC holds
  4. otherwise: PC <= PCPlus4
- Target bits [1:0] are always forced to 0; targets are never misaligned.
- A redirect (JumpTaken or BranchTaken) overrides Stall.
- IF/ID update priority, highest first:
  1. Flush, JumpTaken or BranchTaken: load a bubble. IFID_Instruction=NOP_WORD, IFID_PCPlus4=0, IFID_Valid=0. FetchCount unchanged.
  2. Stall: IF/ID holds all fields. FetchCount unchanged.
  3. otherwise: IFID_Instruction<=InstrIn, IFID_PCPlus4<=PCPlus4, IFID_Valid<=1, FetchCount<=FetchCount+1.
- Flush together with Stall gives a bubble, and the PC still holds (unless a redirect is present).
- FetchCount wraps from 32'hFFFF_FFFF to 0.
- Latency: an instruction at address A appears on IFID_Instruction one edge after PC=A, provided there is no stall or redirect on that edge.
- After Reset deasserts:
  - the first edge latches the word at RESET_PC with IFID_PCPlus4=RESET_PC+4;
  - PC=RESET_PC is presented on PCAddress throughout reset.
- Reset asserted mid-stall or mid-redirect: all state returns to reset values immediately, without waiting for a clock edge.
- Inputs are sampled only at edges. Redirect pulses that are not present at an edge have no effect.

Test Plan:
- Bench memory model returns word_index*3. Reset, release, run 4 edges -> PCAddress 0,4,8,12,16. IF/ID sequence (0,4,V1), (3,8,V1), (6,12,V1), (9,16,V1). FetchCount=4.
- Stall held 2 edges at PC=8 -> PCAddress stays 8. IF/ID holds (3,8,1). FetchCount unchanged. On release the next edge gives IF/ID=(6,12,1).
- BranchTaken=1, BranchTarget=32'h40 at PC=12 -> next PC=0x40, IF/ID bubble (0,0,V0). Following edge IF/ID=(48,0x44,1).
- JumpTaken and BranchTaken both set, JumpTarget=32'h103, BranchTarget=32'h20 -> PC=0x100 (jump wins, LSBs cleared). IF/ID bubble.
- Stall=1 with Flush=1 at PC=0x20 -> PC holds 0x20, IF/ID=(0,0,0). Then Stall=1 with BranchTaken=1, target 0x8 -> PC=0x8.
- Reset pulsed asynchronously between edges during a stall -> PCAddress=RESET_PC, IFID_Valid=0, FetchCount=0 before the next edge. RESET_PC=32'hFFFF_FFFC run 1 edge -> PC wraps to 0, IFID_PCPlus4=0.
